// File: rtl/mitm_chunk_sequencer.sv
// mitm_chunk_sequencer
//
// Sequences chunk-by-chunk transfers for a man-in-the-middle serial bus
// interposer. At the start of every bus transaction it latches the user mode,
// then for each chunk it tells the bus controller to start a chunk of a given
// size. It also decides whether the MISO data seen by the host is the real
// device reply or a substitute pattern. The first MOSI chunk of a transaction
// is treated as the command byte. In SUB_MATCH mode substitution is armed only
// when that command equals MATCH_CMD.
//
// Ports
//   sys_clk          sole clock
//   rst              synchronous active-high reset
//   mode_select      user mode (00/01 forward, 10 substitute all, 11 substitute on match)
//   comm_active      bus transaction in progress
//   bus_ready        bus controller idle and ready for a command
//   real_miso_data   last captured MISO chunk
//   real_mosi_data   last captured MOSI chunk
//   cmd_next_chunk   one-cycle pulse: start the next chunk
//   cmd_finish       one-cycle pulse: end the transaction
//   next_chunk_size  size in bits of the chunk being started
//   fake_miso_select substitute MISO for the chunk being started
//   fake_mosi_select substitute MOSI (never used, always 0)
//   fake_miso_data   substitute MISO pattern
//   fake_mosi_data   substitute MOSI pattern (always 0)
//   chunk_count      chunks completed in the current transaction (saturating)
//   last_cmd         first MOSI chunk of the current/last transaction
//   match_hit        substitution armed for the current/last transaction
module mitm_chunk_sequencer #(
    parameter int                  BUF_SIZE         = 9,
    parameter int                  CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
    parameter int                  MODE_WIDTH       = 2,
    parameter int                  CMD_LEN          = 8,
    parameter logic [CMD_LEN-1:0]  MATCH_CMD        = 8'h03,
    parameter logic [BUF_SIZE-1:0] FAKE_MISO        = 9'h0A5
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic [MODE_WIDTH-1:0]       mode_select,
    input  logic                        comm_active,
    input  logic                        bus_ready,
    input  logic [BUF_SIZE-1:0]         real_miso_data,
    input  logic [BUF_SIZE-1:0]         real_mosi_data,
    output logic                        cmd_next_chunk,
    output logic                        cmd_finish,
    output logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
    output logic                        fake_miso_select,
    output logic                        fake_mosi_select,
    output logic [BUF_SIZE-1:0]         fake_miso_data,
    output logic [BUF_SIZE-1:0]         fake_mosi_data,
    output logic [7:0]                  chunk_count,
    output logic [CMD_LEN-1:0]          last_cmd,
    output logic                        match_hit
);

    localparam logic [MODE_WIDTH-1:0] MODE_FWD       = MODE_WIDTH'(1);
    localparam logic [MODE_WIDTH-1:0] MODE_SUB_ALL   = MODE_WIDTH'(2);
    localparam logic [MODE_WIDTH-1:0] MODE_SUB_MATCH = MODE_WIDTH'(3);

    localparam logic [CHUNK_SIZE_WIDTH-1:0] SIZE_FIRST = CHUNK_SIZE_WIDTH'(CMD_LEN);
    localparam logic [CHUNK_SIZE_WIDTH-1:0] SIZE_FULL  = CHUNK_SIZE_WIDTH'(BUF_SIZE);

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t                state;
    logic [MODE_WIDTH-1:0] mode_q;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Mode 00 is an alias for FORWARD; normalising on latch keeps the
    // rest of the decode to three cases.
    function automatic logic [MODE_WIDTH-1:0] norm_mode(input logic [MODE_WIDTH-1:0] m);
        return (m == '0) ? MODE_FWD : m;
    endfunction

    logic [MODE_WIDTH-1:0] mode_latch;
    logic [CMD_LEN-1:0]    mosi_cmd;
    logic                  cmd_matches;
    logic                  hit_next;
    logic                  first_sel;
    logic [BUF_SIZE-1:0]   first_data;
    logic                  later_sel;
    logic [BUF_SIZE-1:0]   later_data;
    logic                  unused_inputs;

    assign mode_latch  = norm_mode(mode_select);
    assign mosi_cmd    = real_mosi_data[CMD_LEN-1:0];
    assign cmd_matches = (mode_q == MODE_SUB_MATCH) && (mosi_cmd == MATCH_CMD);

    // match_hit as it will be after the chunk completing now: freshly
    // decided when the command chunk completes, otherwise unchanged.
    assign hit_next = (chunk_count == 8'd0) ? cmd_matches : match_hit;

    // The first chunk is the command: only SUB_ALL substitutes it.
    assign first_sel  = (mode_latch == MODE_SUB_ALL);
    assign first_data = (mode_latch == MODE_SUB_ALL) ? FAKE_MISO : '0;

    assign later_sel  = (mode_q == MODE_SUB_ALL) ||
                        ((mode_q == MODE_SUB_MATCH) && hit_next);
    assign later_data = ((mode_q == MODE_SUB_ALL) || (mode_q == MODE_SUB_MATCH)) ?
                        FAKE_MISO : '0;

    // MISO captures and MOSI bits above the command field do not steer
    // the sequencer.
    assign unused_inputs = ^{real_miso_data, real_mosi_data};

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state            <= S_SYNC;
            mode_q           <= MODE_FWD;
            cmd_next_chunk   <= 1'b0;
            cmd_finish       <= 1'b0;
            next_chunk_size  <= '0;
            fake_miso_select <= 1'b0;
            fake_mosi_select <= 1'b0;
            fake_miso_data   <= '0;
            fake_mosi_data   <= '0;
            chunk_count      <= 8'd0;
            last_cmd         <= '0;
            match_hit        <= 1'b0;
        end else begin
            // Command outputs are single-cycle pulses.
            cmd_next_chunk <= 1'b0;
            cmd_finish     <= 1'b0;

            case (state)
                // Never join a transaction that is already in flight.
                S_SYNC: begin
                    if (!comm_active) begin
                        state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (comm_active && bus_ready) begin
                        mode_q           <= mode_latch;
                        chunk_count      <= 8'd0;
                        match_hit        <= 1'b0;
                        cmd_next_chunk   <= 1'b1;
                        next_chunk_size  <= SIZE_FIRST;
                        fake_miso_select <= first_sel;
                        fake_miso_data   <= first_data;
                        fake_mosi_select <= 1'b0;
                        fake_mosi_data   <= '0;
                        state            <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    state <= S_WAIT_BUSY;
                end

                // Host ended the transaction before the chunk started:
                // nothing was transferred, so the count is left alone.
                S_WAIT_BUSY: begin
                    if (!comm_active && bus_ready) begin
                        cmd_finish <= 1'b1;
                        state      <= S_FINISH;
                    end else if (!bus_ready) begin
                        state <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (bus_ready) begin
                        chunk_count <= sat_inc8(chunk_count);
                        if (chunk_count == 8'd0) begin
                            last_cmd  <= mosi_cmd;
                            match_hit <= cmd_matches;
                        end
                        if (comm_active) begin
                            cmd_next_chunk   <= 1'b1;
                            next_chunk_size  <= SIZE_FULL;
                            fake_miso_select <= later_sel;
                            fake_miso_data   <= later_data;
                            fake_mosi_select <= 1'b0;
                            fake_mosi_data   <= '0;
                            state            <= S_ISSUE;
                        end else begin
                            cmd_finish <= 1'b1;
                            state      <= S_FINISH;
                        end
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_SYNC;
                end
            endcase
        end
    end

endmodule

// File: doc/mitm_chunk_sequencer.md
MITM_CHUNK_SEQUENCER -- requirements
Module: mitm_chunk_sequencer

Interface
REQ-001 SHALL have parameters: BUF_SIZE, 9, chunk buffer width in bits; CHUNK_SIZE_WIDTH, $clog2(BUF_SIZE+1), size field width; MODE_WIDTH, 2, mode bus width; CMD_LEN, 8, first-chunk length in bits (1..BUF_SIZE); MATCH_CMD, 8'h03, MOSI command value that arms substitution; FAKE_MISO, 9'h0A5, substitute MISO pattern.
REQ-002 SHALL have ports: sys_clk in 1, sole clock; rst in 1, synchronous active-high reset; mode_select in MODE_WIDTH, user mode; comm_active in 1, bus transaction in progress; bus_ready in 1, bus controller idle and ready for a command; real_miso_data in BUF_SIZE, last captured MISO chunk; real_mosi_data in BUF_SIZE, last captured MOSI chunk.
REQ-003 SHALL have ports: cmd_next_chunk out 1, start-chunk pulse; cmd_finish out 1, end-transaction pulse; next_chunk_size out CHUNK_SIZE_WIDTH; fake_miso_select out 1; fake_mosi_select out 1; fake_miso_data out BUF_SIZE; fake_mosi_data out BUF_SIZE; chunk_count out 8, chunks completed in current transaction; last_cmd out CMD_LEN, latched first MOSI chunk; match_hit out 1, substitution armed.
REQ-004 One clock (sys_clk); reset rst is synchronous, active-high; all outputs registered.

Function
REQ-005 Modes: 2'b01 FORWARD, 2'b10 SUB_ALL, 2'b11 SUB_MATCH; 2'b00 SHALL behave as FORWARD.
REQ-006 States: SYNC, IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH.
REQ-007 SYNC: stay while comm_active=1; go IDLE when comm_active=0 (never join a transaction mid-flight).
REQ-008 IDLE: when comm_active=1 and bus_ready=1 -> latch mode_select into mode_q, clear chunk_count and match_hit, go ISSUE; mode_select changes after latching SHALL be ignored until next IDLE.
REQ-009 ISSUE: assert cmd_next_chunk for exactly one cycle; in the same cycle drive next_chunk_size, fake_*_select, fake_*_data; hold those values until the next ISSUE; go WAIT_BUSY.
REQ-010 Chunk size: first chunk (chunk_count=0) = CMD_LEN; later chunks = BUF_SIZE.
REQ-011 fake_mosi_select SHALL always be 0, fake_mosi_data 0.
REQ-012 FORWARD: fake_miso_select=0 all chunks. SUB_ALL: fake_miso_select=1, fake_miso_data=FAKE_MISO, all chunks including first. SUB_MATCH: first chunk select=0; later chunks select=match_hit, data=FAKE_MISO.
REQ-013 WAIT_BUSY: go WAIT_DONE when bus_ready=0; if comm_active=0 and bus_ready=1 -> FINISH.
REQ-014 WAIT_DONE: on bus_ready=1 -> chunk_count +1 (saturate at 255); if chunk_count was 0, latch last_cmd = real_mosi_data[CMD_LEN-1:0] and set match_hit = (mode_q=SUB_MATCH and that value = MATCH_CMD); then ISSUE if comm_active=1, else FINISH.
REQ-015 comm_active=0 together with bus_ready=1 in any WAIT state SHALL take priority over continuing; the partially transferred chunk is counted only if reached via WAIT_DONE.
REQ-016 FINISH: assert cmd_finish for exactly one cycle, go IDLE; chunk_count, last_cmd, match_hit hold until next IDLE->ISSUE.
REQ-017 cmd_next_chunk and cmd_finish SHALL never be high in the same cycle.
REQ-018 Latency: IDLE trigger -> cmd_next_chunk 1 cycle; WAIT_DONE bus_ready=1 -> next cmd_next_chunk 1 cycle later.

Reset
REQ-019 On rst=1 at a sys_clk edge: state=SYNC; cmd_next_chunk=0, cmd_finish=0, next_chunk_size=0, fake selects=0, fake data=0, chunk_count=0, last_cmd=0, match_hit=0, mode_q=FORWARD.
REQ-020 Reset mid-transaction SHALL abort without emitting cmd_finish; resume only after comm_active=0 observed.

Verification
REQ-021 FORWARD, 3 chunks (MOSI 0x9F first): cmd_next_chunk sizes 8,9,9, fake_miso_select=0, then cmd_finish pulse, chunk_count=3, last_cmd=0x9F, match_hit=0.
REQ-022 SUB_ALL, 2 chunks: both chunks fake_miso_select=1, fake_miso_data=0x0A5; cmd_finish after comm_active falls.
REQ-023 SUB_MATCH, first MOSI 0x03: chunk 1 select=0, chunks 2+ select=1 data=0x0A5, match_hit=1; repeat with 0x05: all selects 0, match_hit=0.
REQ-024 mode_select toggled FORWARD->SUB_ALL mid-transaction: no change until next transaction, which uses SUB_ALL.
REQ-025 rst during WAIT_DONE with comm_active=1: no cmd_finish, no cmd_next_chunk until comm_active low then high with bus_ready=1.
REQ-026 comm_active drops in WAIT_BUSY with bus_ready=1: single cmd_finish, chunk_count unchanged, pulses never overlap.
